// File: rtl/exanet_crosb_pkg.sv
// Shared types and helpers for the ExaNet crossbar egress path.
//   sched_state_t : link scheduler FSM state (IDLE waits for an eligible VC,
//                   XFER owns the link until the footer handshake).
//   credit_next   : next packet-credit count from one return and one grant,
//                   clamped to [0, max].
package exanet_crosb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } sched_state_t;

  // A return and a grant in the same cycle cancel out. A lone return at the
  // ceiling is clamped; the caller flags that case as a credit error.
  function automatic int credit_next(input int cur, input logic ret,
                                     input logic dec, input int max);
    if (ret && !dec) return (cur >= max) ? max : cur + 1;
    if (dec && !ret) return (cur > 0) ? cur - 1 : 0;
    return cur;
  endfunction

endpackage

// File: rtl/exa_crosb_rr_arbiter.sv
// N-input round-robin arbiter with an explicit pointer update.
//   clk, rst_n : clock, asynchronous active-low reset (pointer -> 0)
//   req        : request vector
//   upd_en     : move the pointer to just past upd_idx on this edge
//   upd_idx    : index of the requester that completed its transfer
//   gnt_any    : at least one request is set (combinational)
//   gnt_idx    : first requester at or after the pointer (combinational)
// The pointer only moves when the owner of a grant finishes, so a grant that
// is offered but not consumed does not disturb fairness.
module exa_crosb_rr_arbiter #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          upd_en,
  input  logic [IW-1:0] upd_idx,
  output logic          gnt_any,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr;
  int            idx;

  // Scan from the farthest offset down so the nearest requester at or after
  // the pointer is the last one written and therefore wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N;
      if (req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (upd_en) begin
      ptr <= (upd_idx == IW'(N - 1)) ? '0 : upd_idx + IW'(1);
    end
  end

endmodule

// File: rtl/exa_crosb_vc_link_scheduler.sv
// Per-output-port link scheduler: picks which (prio,vc) queue sends its next
// packet, holds the link for the whole packet and tracks per-VC packet credits
// for the downstream receiver.
//   ACLK, ARESETN           : clock, asynchronous active-low reset
//   i_enable                : 0 blocks new grants (packet in flight continues)
//   i_vc_has_packet         : a complete packet waits at the head of VC n
//   o_grant_valid/_vc       : link owner; upstream muxes that VC onto i_*
//   i_data, i_*_valid       : muxed upstream stream -> o_data, o_*_valid
//   i_*_ready               : link readies -> o_*_ready upstream
//   i_credit_ret_valid/_vc  : downstream freed one packet slot of a VC
//   o_credits               : VC n count at [n*CNT_W +: CNT_W]
//   o_credit_err            : sticky overflow / out-of-range return flag
//   o_dbg_state             : FSM state
// Handshake: a beat of kind X transfers on a cycle where X valid and X ready
// are both high; valid is held with stable data until it transfers. The
// scheduler only forwards these signals while it owns the link (XFER) and
// drives them all to 0 otherwise.
module exa_crosb_vc_link_scheduler
  import exanet_crosb_pkg::*;
#(
  parameter  int prio_num   = 2,
  parameter  int vc_num     = 3,
  parameter  int CREDIT_MAX = 40,
  parameter  int DATA_WIDTH = 128,
  localparam int NUM_VC     = prio_num * vc_num,
  localparam int logVcPrio  = $clog2(NUM_VC),
  localparam int CNT_W      = $clog2(CREDIT_MAX + 1),
  localparam int LW         = (vc_num > 1) ? $clog2(vc_num) : 1
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    i_enable,
  input  logic [NUM_VC-1:0]       i_vc_has_packet,
  output logic                    o_grant_valid,
  output logic [logVcPrio-1:0]    o_grant_vc,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic                    i_header_valid,
  input  logic                    i_payload_valid,
  input  logic                    i_footer_valid,
  output logic                    o_header_ready,
  output logic                    o_payload_ready,
  output logic                    o_footer_ready,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic                    o_header_valid,
  output logic                    o_payload_valid,
  output logic                    o_footer_valid,
  input  logic                    i_header_ready,
  input  logic                    i_payload_ready,
  input  logic                    i_footer_ready,
  input  logic                    i_credit_ret_valid,
  input  logic [logVcPrio-1:0]    i_credit_ret_vc,
  output logic [NUM_VC*CNT_W-1:0] o_credits,
  output logic                    o_credit_err,
  output sched_state_t            o_dbg_state
);

  sched_state_t          state;
  logic [CNT_W-1:0]      credit   [NUM_VC];
  logic [CNT_W-1:0]      credit_d [NUM_VC];
  logic [NUM_VC-1:0]     eligible;
  logic [NUM_VC-1:0]     ret_hit;
  logic [NUM_VC-1:0]     dec_hit;
  logic [NUM_VC-1:0]     ovf;
  logic                  ret_bad;
  logic [prio_num-1:0]   cls_any;
  logic [LW-1:0]         cls_idx [prio_num];
  logic [prio_num-1:0]   cls_upd;
  logic                  pick_any;
  logic [logVcPrio-1:0]  pick_vc;
  logic                  grant_now;
  logic                  in_xfer;
  logic                  footer_hs;
  int                    owner_prio;
  logic [LW-1:0]         owner_local;

  assign in_xfer   = (state == XFER);
  assign footer_hs = in_xfer & i_footer_valid & i_footer_ready;
  assign grant_now = (state == IDLE) & pick_any;

  always_comb begin
    for (int n = 0; n < NUM_VC; n++) begin
      eligible[n] = i_vc_has_packet[n] & (credit[n] != '0) & i_enable;
    end
  end

  // Only the class that owns the link advances its pointer, and only once
  // the owning VC's footer has been accepted.
  always_comb begin
    owner_prio  = int'(o_grant_vc) / vc_num;
    owner_local = LW'(int'(o_grant_vc) % vc_num);
    for (int p = 0; p < prio_num; p++) begin
      cls_upd[p] = footer_hs && (owner_prio == p);
    end
  end

  for (genvar p = 0; p < prio_num; p++) begin : g_cls
    exa_crosb_rr_arbiter #(.N(vc_num)) u_rr (
      .clk     (ACLK),
      .rst_n   (ARESETN),
      .req     (eligible[p*vc_num +: vc_num]),
      .upd_en  (cls_upd[p]),
      .upd_idx (owner_local),
      .gnt_any (cls_any[p]),
      .gnt_idx (cls_idx[p])
    );
  end

  // Strict priority: scanning upwards lets the highest active class win.
  always_comb begin
    pick_any = 1'b0;
    pick_vc  = '0;
    for (int p = 0; p < prio_num; p++) begin
      if (cls_any[p]) begin
        pick_any = 1'b1;
        pick_vc  = logVcPrio'(p * vc_num + int'(cls_idx[p]));
      end
    end
  end

  always_comb begin
    ret_bad = i_credit_ret_valid && (int'(i_credit_ret_vc) >= NUM_VC);
    for (int n = 0; n < NUM_VC; n++) begin
      ret_hit[n]  = i_credit_ret_valid && (i_credit_ret_vc == logVcPrio'(n));
      dec_hit[n]  = grant_now && (pick_vc == logVcPrio'(n));
      ovf[n]      = ret_hit[n] & ~dec_hit[n] & (credit[n] >= CNT_W'(CREDIT_MAX));
      credit_d[n] = CNT_W'(credit_next(int'(credit[n]), ret_hit[n], dec_hit[n],
                                       CREDIT_MAX));
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state         <= IDLE;
      o_grant_valid <= 1'b0;
      o_grant_vc    <= '0;
      o_credit_err  <= 1'b0;
      for (int n = 0; n < NUM_VC; n++) credit[n] <= CNT_W'(CREDIT_MAX);
    end else begin
      for (int n = 0; n < NUM_VC; n++) credit[n] <= credit_d[n];
      if (ret_bad || (ovf != '0)) o_credit_err <= 1'b1;
      case (state)
        IDLE: begin
          if (pick_any) begin
            o_grant_valid <= 1'b1;
            o_grant_vc    <= pick_vc;
            state         <= XFER;
          end
        end
        XFER: begin
          if (footer_hs) begin
            o_grant_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Link path is a plain wire-through while the link is owned.
  assign o_data          = in_xfer ? i_data : '0;
  assign o_header_valid  = in_xfer & i_header_valid;
  assign o_payload_valid = in_xfer & i_payload_valid;
  assign o_footer_valid  = in_xfer & i_footer_valid;
  assign o_header_ready  = in_xfer & i_header_ready;
  assign o_payload_ready = in_xfer & i_payload_ready;
  assign o_footer_ready  = in_xfer & i_footer_ready;
  assign o_dbg_state     = state;

  always_comb begin
    for (int n = 0; n < NUM_VC; n++) o_credits[n*CNT_W +: CNT_W] = credit[n];
  end

endmodule

// File: tb/tb_exa_crosb_vc_link_scheduler.sv
// Bench for the link scheduler: scenario tasks drive packets and credit
// returns while a reference model (per-VC credits, per-class pointers,
// pending-packet counts) predicts every grant and credit value.
module tb_exa_crosb_vc_link_scheduler;
  import exanet_crosb_pkg::*;

  localparam int PN = 2;
  localparam int VCN = 3;
  localparam int NV = PN * VCN;
  localparam int CW = 6;
  localparam int CMAX = 40;
  localparam int DW = 128;

  logic            clk;
  logic            rst_n;
  logic            i_enable;
  logic [NV-1:0]   i_vc_has_packet;
  logic            o_grant_valid;
  logic [2:0]      o_grant_vc;
  logic [DW-1:0]   i_data;
  logic            i_header_valid, i_payload_valid, i_footer_valid;
  logic            o_header_ready, o_payload_ready, o_footer_ready;
  logic [DW-1:0]   o_data;
  logic            o_header_valid, o_payload_valid, o_footer_valid;
  logic            i_header_ready, i_payload_ready, i_footer_ready;
  logic            i_credit_ret_valid;
  logic [2:0]      i_credit_ret_vc;
  logic [NV*CW-1:0] o_credits;
  logic            o_credit_err;
  sched_state_t    o_dbg_state;

  exa_crosb_vc_link_scheduler dut (
    .ACLK(clk), .ARESETN(rst_n), .i_enable(i_enable),
    .i_vc_has_packet(i_vc_has_packet),
    .o_grant_valid(o_grant_valid), .o_grant_vc(o_grant_vc),
    .i_data(i_data),
    .i_header_valid(i_header_valid), .i_payload_valid(i_payload_valid),
    .i_footer_valid(i_footer_valid),
    .o_header_ready(o_header_ready), .o_payload_ready(o_payload_ready),
    .o_footer_ready(o_footer_ready),
    .o_data(o_data),
    .o_header_valid(o_header_valid), .o_payload_valid(o_payload_valid),
    .o_footer_valid(o_footer_valid),
    .i_header_ready(i_header_ready), .i_payload_ready(i_payload_ready),
    .i_footer_ready(i_footer_ready),
    .i_credit_ret_valid(i_credit_ret_valid), .i_credit_ret_vc(i_credit_ret_vc),
    .o_credits(o_credits), .o_credit_err(o_credit_err),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int  exp_credit [NV];
  int  exp_ptr    [PN];
  int  pend       [NV];
  bit  exp_err;
  bit  en_model;
  bit  ret_pend_valid;
  int  ret_pend_vc;
  int  tests_run;
  int  tests_failed;

  function automatic void model_reset();
    for (int n = 0; n < NV; n++) begin
      exp_credit[n] = CMAX;
      pend[n] = 0;
    end
    for (int p = 0; p < PN; p++) exp_ptr[p] = 0;
    exp_err = 1'b0;
    en_model = 1'b1;
    ret_pend_valid = 1'b0;
    ret_pend_vc = 0;
  endfunction

  // Highest class first; inside a class, first VC at or after the pointer
  // that has a packet and a credit.
  function automatic int model_pick();
    if (!en_model) return -1;
    for (int p = PN - 1; p >= 0; p--) begin
      for (int k = 0; k < VCN; k++) begin
        int n;
        n = p * VCN + (exp_ptr[p] + k) % VCN;
        if (pend[n] > 0 && exp_credit[n] > 0) return n;
      end
    end
    return -1;
  endfunction

  function automatic logic [NV*CW-1:0] exp_credit_vec();
    logic [NV*CW-1:0] v;
    for (int n = 0; n < NV; n++) v[n*CW +: CW] = CW'(exp_credit[n]);
    return v;
  endfunction

  function automatic int pend_total();
    int s;
    s = 0;
    for (int n = 0; n < NV; n++) s += pend[n];
    return s;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_link_idle();
    i_data = '0;
    i_header_valid = 1'b0; i_payload_valid = 1'b0; i_footer_valid = 1'b0;
    i_header_ready = 1'b0; i_payload_ready = 1'b0; i_footer_ready = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    i_enable = 1'b1;
    i_vc_has_packet = '0;
    i_credit_ret_valid = 1'b0;
    i_credit_ret_vc = '0;
    drive_link_idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  // Streams one packet for the VC that owns the link. Random link readies
  // stall beats; the footer is held unready for fstall cycles.
  task automatic send_packet(input int vc, input int nhdr, input int npay,
                             input int fstall);
    int nbeats;
    nbeats = nhdr + npay + 1;
    for (int b = 0; b < nbeats; b++) begin
      int kind;
      int tries;
      bit done;
      kind = (b < nhdr) ? 0 : ((b < nhdr + npay) ? 1 : 2);
      tries = 0;
      done = 1'b0;
      i_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      while (!done) begin
        i_header_valid  = (kind == 0);
        i_payload_valid = (kind == 1);
        i_footer_valid  = (kind == 2);
        i_header_ready  = 1'($urandom_range(0, 1));
        i_payload_ready = 1'($urandom_range(0, 1));
        i_footer_ready  = 1'($urandom_range(0, 1));
        if (kind == 0) i_header_ready  = (tries >= 2) || ($urandom_range(0, 3) != 0);
        if (kind == 1) i_payload_ready = (tries >= 2) || ($urandom_range(0, 3) != 0);
        if (kind == 2) i_footer_ready  = (tries >= fstall);
        i_enable = (kind == 2) ? 1'b1 : 1'($urandom_range(0, 1));
        #1;
        tests_run++;
        if ({o_data, o_header_valid, o_payload_valid, o_footer_valid,
             o_header_ready, o_payload_ready, o_footer_ready, o_grant_valid, o_grant_vc}
            !== {i_data, i_header_valid, i_payload_valid, i_footer_valid,
                 i_header_ready, i_payload_ready, i_footer_ready, 1'b1, 3'(vc)}) begin
          tests_failed++;
          $display("FAIL passthrough vc=%0d beat=%0d kind=%0d: got data=%h v/r=%b%b%b%b%b%b grant=%b/%0d, want data=%h v/r=%b%b%b%b%b%b grant=1/%0d",
                   vc, b, kind, o_data, o_header_valid, o_payload_valid, o_footer_valid,
                   o_header_ready, o_payload_ready, o_footer_ready, o_grant_valid, o_grant_vc,
                   i_data, i_header_valid, i_payload_valid, i_footer_valid,
                   i_header_ready, i_payload_ready, i_footer_ready, vc);
        end
        done = (kind == 0) ? i_header_ready : ((kind == 1) ? i_payload_ready : i_footer_ready);
        tries++;
        @(negedge clk);
      end
    end
    drive_link_idle();
    i_enable = en_model;
    exp_ptr[vc / VCN] = (vc % VCN + 1) % VCN;
    #1;
    tests_run++;
    if ({o_grant_valid, o_dbg_state, o_header_valid, o_payload_valid, o_footer_valid}
        !== {1'b0, IDLE, 3'b000}) begin
      tests_failed++;
      $display("FAIL release vc=%0d: got grant=%b state=%0d valids=%b%b%b, want grant=0 state=IDLE valids=000",
               vc, o_grant_valid, o_dbg_state, o_header_valid, o_payload_valid, o_footer_valid);
    end
  endtask

  // One arbitration slot: present pending VCs (and an optional credit return),
  // check the predicted grant and all credits, then run the granted packet.
  task automatic serve_one(input int nhdr, input int npay, input int fstall,
                           output int got_vc);
    int pred;
    for (int n = 0; n < NV; n++) i_vc_has_packet[n] = (pend[n] > 0);
    i_enable = en_model;
    i_credit_ret_valid = ret_pend_valid;
    i_credit_ret_vc = 3'(ret_pend_vc);
    pred = model_pick();
    if (pred >= 0) begin
      exp_credit[pred]--;
      pend[pred]--;
    end
    if (ret_pend_valid) begin
      if (ret_pend_vc >= NV) exp_err = 1'b1;
      else if (ret_pend_vc == pred) exp_credit[pred]++;
      else if (exp_credit[ret_pend_vc] >= CMAX) exp_err = 1'b1;
      else exp_credit[ret_pend_vc]++;
    end
    ret_pend_valid = 1'b0;
    @(negedge clk);
    i_credit_ret_valid = 1'b0;
    tests_run++;
    if (pred >= 0) begin
      if ({o_grant_valid, o_grant_vc, o_dbg_state} !== {1'b1, 3'(pred), XFER}) begin
        tests_failed++;
        $display("FAIL grant: got valid=%b vc=%0d state=%0d, want valid=1 vc=%0d state=XFER",
                 o_grant_valid, o_grant_vc, o_dbg_state, pred);
      end
    end else begin
      if ({o_grant_valid, o_dbg_state} !== {1'b0, IDLE}) begin
        tests_failed++;
        $display("FAIL no_grant: got valid=%b vc=%0d state=%0d, want valid=0 state=IDLE",
                 o_grant_valid, o_grant_vc, o_dbg_state);
      end
    end
    tests_run++;
    if ({o_credits, o_credit_err} !== {exp_credit_vec(), exp_err}) begin
      tests_failed++;
      $display("FAIL credits: got %h err=%b, want %h err=%b",
               o_credits, o_credit_err, exp_credit_vec(), exp_err);
    end
    got_vc = pred;
    if (pred >= 0) send_packet(pred, nhdr, npay, fstall);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [NV*CW-1:0] all_max;
    for (int n = 0; n < NV; n++) all_max[n*CW +: CW] = CW'(CMAX);
    apply_reset();
    tests_run++;
    if ({o_credits, o_credit_err, o_grant_valid, o_grant_vc, o_dbg_state} !==
        {all_max, 1'b0, 1'b0, 3'd0, IDLE}) begin
      tests_failed++;
      $display("FAIL reset_state: got credits=%h err=%b grant=%b/%0d state=%0d, want credits=%h err=0 grant=0/0 state=IDLE",
               o_credits, o_credit_err, o_grant_valid, o_grant_vc, o_dbg_state, all_max);
    end
    tests_run++;
    if ({o_data, o_header_valid, o_payload_valid, o_footer_valid,
         o_header_ready, o_payload_ready, o_footer_ready} !== '0) begin
      tests_failed++;
      $display("FAIL reset_link: got data=%h v/r=%b%b%b%b%b%b, want all 0", o_data,
               o_header_valid, o_payload_valid, o_footer_valid,
               o_header_ready, o_payload_ready, o_footer_ready);
    end
  endtask

  task automatic test_single_packet();
    int got;
    pend[0] = 1;
    serve_one(1, 4, 0, got);
    tests_run++;
    if (o_credits[0 +: CW] !== 6'd39) begin
      tests_failed++;
      $display("FAIL single_credit0: got %0d, want 39", o_credits[0 +: CW]);
    end
    serve_one(1, 0, 0, got);
  endtask

  task automatic test_rr_class0();
    int got;
    int order [9];
    for (int n = 0; n < VCN; n++) pend[n] = 3;
    for (int i = 0; i < 9; i++) begin
      serve_one($urandom_range(1, 2), $urandom_range(0, 2), 0, got);
      order[i] = got;
    end
    tests_run++;
    if ({order[0], order[1], order[2], order[3]} !== {32'd1, 32'd2, 32'd0, 32'd1}) begin
      tests_failed++;
      $display("FAIL rr_order: got %0d,%0d,%0d,%0d, want 1,2,0,1",
               order[0], order[1], order[2], order[3]);
    end
    serve_one(1, 0, 0, got);
  endtask

  task automatic test_strict_priority();
    int got;
    int first;
    pend[0] = 2;
    pend[3] = 2;
    serve_one(1, 1, 0, first);
    tests_run++;
    if (first != 3 || o_credits[3*CW +: CW] !== 6'd39) begin
      tests_failed++;
      $display("FAIL prio_first: got vc=%0d credit3=%0d, want vc=3 credit3=39",
               first, o_credits[3*CW +: CW]);
    end
    for (int i = 0; i < 4; i++) serve_one(1, $urandom_range(0, 3), 0, got);
  endtask

  task automatic test_enable();
    int got;
    pend[1] = 1;
    en_model = 1'b0;
    serve_one(1, 0, 0, got);
    serve_one(1, 0, 0, got);
    en_model = 1'b1;
    serve_one(1, 2, 0, got);
  endtask

  task automatic test_footer_stall();
    int got;
    pend[0] = 1;
    pend[1] = 1;
    pend[3] = 1;
    serve_one(1, 2, 5, got);
    for (int i = 0; i < 3; i++) serve_one(1, 1, $urandom_range(0, 2), got);
  endtask

  task automatic test_credit_drain();
    int got;
    apply_reset();
    pend[2] = CMAX;
    for (int i = 0; i < CMAX; i++) serve_one(1, 0, 0, got);
    tests_run++;
    if (o_credits[2*CW +: CW] !== 6'd0) begin
      tests_failed++;
      $display("FAIL drain_credit2: got %0d, want 0", o_credits[2*CW +: CW]);
    end
    pend[2] = 1;
    pend[1] = 1;
    serve_one(1, 0, 0, got);
    serve_one(1, 0, 0, got);
    ret_pend_valid = 1'b1;
    ret_pend_vc = 2;
    serve_one(1, 0, 0, got);
    serve_one(1, 1, 0, got);
    tests_run++;
    if (got != 2 || o_credits[2*CW +: CW] !== 6'd0) begin
      tests_failed++;
      $display("FAIL drain_regrant: got vc=%0d credit2=%0d, want vc=2 credit2=0",
               got, o_credits[2*CW +: CW]);
    end
  endtask

  task automatic test_credit_returns();
    int got;
    apply_reset();
    pend[1] = 1;
    ret_pend_valid = 1'b1;
    ret_pend_vc = 1;
    serve_one(1, 1, 0, got);
    tests_run++;
    if (o_credits[1*CW +: CW] !== 6'd40 || o_credit_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL same_cycle: got credit1=%0d err=%b, want 40 err=0",
               o_credits[1*CW +: CW], o_credit_err);
    end
    ret_pend_valid = 1'b1;
    ret_pend_vc = 4;
    serve_one(1, 0, 0, got);
    tests_run++;
    if (o_credits[4*CW +: CW] !== 6'd40 || o_credit_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL overflow: got credit4=%0d err=%b, want 40 err=1",
               o_credits[4*CW +: CW], o_credit_err);
    end
    apply_reset();
    ret_pend_valid = 1'b1;
    ret_pend_vc = 6;
    serve_one(1, 0, 0, got);
  endtask

  task automatic test_random();
    int got;
    apply_reset();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 1) pend[$urandom_range(0, NV - 1)] += $urandom_range(1, 3);
      if ($urandom_range(0, 2) == 0) begin
        int v;
        v = $urandom_range(0, NV - 1);
        if (exp_credit[v] < CMAX) begin
          ret_pend_valid = 1'b1;
          ret_pend_vc = v;
        end
      end
      serve_one($urandom_range(1, 2), $urandom_range(0, 3), $urandom_range(0, 2), got);
    end
    for (int i = 0; i < 300; i++) begin
      if (pend_total() == 0) break;
      serve_one(1, $urandom_range(0, 2), 0, got);
    end
    for (int n = 0; n < NV; n++) pend[n] = 0;
    serve_one(1, 0, 0, got);
  endtask

  task automatic test_reset_mid_packet();
    logic [NV*CW-1:0] all_max;
    for (int n = 0; n < NV; n++) all_max[n*CW +: CW] = CW'(CMAX);
    apply_reset();
    i_vc_has_packet = 6'b010000;
    @(negedge clk);
    i_header_valid = 1'b1;
    i_header_ready = 1'b1;
    @(negedge clk);
    i_header_valid = 1'b0;
    i_payload_valid = 1'b1;
    i_payload_ready = 1'b1;
    i_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    #1;
    tests_run++;
    if ({o_grant_valid, o_grant_vc, o_payload_valid, o_credits[4*CW +: CW]} !==
        {1'b1, 3'd4, 1'b1, 6'd39}) begin
      tests_failed++;
      $display("FAIL midpkt_before: got grant=%b/%0d pvalid=%b credit4=%0d, want 1/4 1 39",
               o_grant_valid, o_grant_vc, o_payload_valid, o_credits[4*CW +: CW]);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({o_data, o_header_valid, o_payload_valid, o_footer_valid, o_header_ready,
         o_payload_ready, o_footer_ready, o_grant_valid, o_grant_vc, o_credits, o_credit_err}
        !== {{DW{1'b0}}, 6'b0, 1'b0, 3'd0, all_max, 1'b0}) begin
      tests_failed++;
      $display("FAIL midpkt_reset: got data=%h pvalid=%b grant=%b/%0d credits=%h err=%b, want all 0, credits=%h",
               o_data, o_payload_valid, o_grant_valid, o_grant_vc, o_credits, o_credit_err, all_max);
    end
    @(negedge clk);
    drive_link_idle();
    i_vc_has_packet = '0;
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    tests_run = 0;
    tests_failed = 0;
    model_reset();
    test_reset();
    test_single_packet();
    test_rr_class0();
    test_strict_priority();
    test_enable();
    test_footer_stall();
    test_credit_drain();
    test_credit_returns();
    test_random();
    test_reset_mid_packet();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/exa_crosb_vc_link_scheduler.md
Name: exa_crosb_vc_link_scheduler

Overview:
Egress stage directly downstream of the per-output VC-aware s2e stage. One instance per switch output port. It picks which (prio,vc) queue may send its next packet onto the physical ExaNet link, holds the link for the whole packet, and keeps per-VC packet credits for the downstream receiver's input FIFOs. It uses strict priority between priority classes and round-robin among the VCs inside a class.

Parameters:
prio_num, 2, number of priority classes; class prio_num-1 has the highest priority
vc_num, 3, VCs per priority class; flat VC index = prio*vc_num + vc
NUM_VC, prio_num*vc_num, localparam, total queues
logVcPrio, `log2(NUM_VC), VC index width
CREDIT_MAX, 40, initial and maximum packet credits per VC (downstream in_fifo_depth)
CNT_W, `log2(CREDIT_MAX+1), credit counter width
DATA_WIDTH, 128, ExaNet data width

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
i_enable  in  1  from cntrl_info; 0 blocks new grants only
i_vc_has_packet  in  NUM_VC  a complete packet is queued at the head of VC n
o_grant_valid  out  1  a VC owns the link
o_grant_vc  out  logVcPrio  index of the owning VC; upstream muxes that VC onto the i_* stream
i_data  in  DATA_WIDTH  muxed upstream data
i_header_valid/i_payload_valid/i_footer_valid  in  1 each  upstream valids
o_header_ready/o_payload_ready/o_footer_ready  out  1 each  readies returned upstream
o_data  out  DATA_WIDTH  link data
o_header_valid/o_payload_valid/o_footer_valid  out  1 each  link valids
i_header_ready/i_payload_ready/i_footer_ready  in  1 each  link readies
i_credit_ret_valid  in  1  downstream freed one packet slot
i_credit_ret_vc  in  logVcPrio  VC of the returned credit
o_credits  out  NUM_VC*CNT_W  current credit count per VC; VC n is at bits [n*CNT_W +: CNT_W]
o_credit_err  out  1  sticky; set on overflow or on a return with an out-of-range VC index

Behaviour:
- Reset (async, ARESETN=0):
  - state = IDLE; all RR pointers = 0.
  - Every credit counter = CREDIT_MAX; o_credit_err = 0.
  - o_grant_valid = 0, o_grant_vc = 0.
  - All o_*valid and o_*ready = 0; o_data = 0.
- Reset asserted mid-packet aborts the packet. Recovering the partner's state is out of scope.
- eligible[n] = i_vc_has_packet[n] & (credit[n] != 0) & i_enable.
- FSM IDLE:
  - If any eligible bit is set, select the highest class that has an eligible VC.
  - Within that class, pick round-robin starting at the class pointer.
  - Registered: o_grant_vc = n, o_grant_valid = 1, credit[n] decrements, state = XFER.
  - Grant latency: 1 cycle after eligibility is sampled.
- FSM XFER:
  - Pure combinational pass-through: o_data = i_data, o_X_valid = i_X_valid, o_X_ready = i_X_ready, for X = header/payload/footer.
  - Packet order is header beats, then payload beats, then exactly one footer beat.
  - On the footer handshake (i_footer_valid & i_footer_ready): state = IDLE, o_grant_valid = 0 on the next cycle, and the class pointer moves to (vc+1) mod vc_num.
  - Minimum gap between packets: 1 idle cycle.
- Outside XFER, all o_*valid and o_*ready are 0.
- i_enable falling during XFER does not interrupt the packet in flight.
- Credit update each cycle: credit[n] += (return for n) - (grant for n).
  - A return and a grant to the same VC in the same cycle leave the count unchanged.
  - A return to a VC already at CREDIT_MAX saturates the count and sets o_credit_err.
  - A return whose VC index is >= NUM_VC is ignored and sets o_credit_err.
- A VC at credit 0 is never granted, even while others of its class are eligible.
- RR pointers advance only on completed packets.

Decomposition:
- Add to exanet_crosb_pkg:
  - typedef sched_state_t {IDLE, XFER}
  - function credit_next(cur, ret, dec), with saturation
- Natural sub-module: exa_crosb_rr_arbiter, a parameterised N-input round-robin with a pointer-update-enable input. Instantiate prio_num copies of width vc_num, followed by a strict-priority select over the copies.

Test Plan:
- After reset: o_credits equals 40 in every field, grant_valid = 0. Set has_packet[0] = 1 → grant_vc = 0 one cycle later, credit[0] = 39. A packet of 1 header + 4 payload + 1 footer passes through unmodified, then the block returns to IDLE.
- has_packet = 6'b000111, all in class 0, each VC sends 3 packets → grant order 0,1,2,0,1,2,…
- has_packet[0] and has_packet[3] set together → VC 3 (class 1) is granted first; VC 0 only once VC 3 drops.
- Drain credit[2] to 0 with 40 packets → VC 2 is skipped. One return for VC 2 → VC 2 is granted again.
- Return for VC 1 in the same cycle as VC 1's grant → credit[1] is unchanged. A return to VC 4 at 40 → stays at 40, o_credit_err = 1.
- Hold i_footer_ready = 0 for 5 cycles mid-packet → grant is held and no other VC is granted. Pulse ARESETN low mid-payload → all outputs drop to 0 immediately and credits return to 40.
